fifo_stream_reader: RTL

//  Read-side engine for the synchronous FIFO: drains words through the FIFO's registered read port
//  (cs/rd_ena/empty, 1-cycle read latency) and presents them on a valid/ready stream.
//  A 2-entry output buffer absorbs the in-flight word under backpressure, so no word is lost or duplicated.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_out_skid.sv | 71 +++++++
 rtl/fifo_stream_reader.sv | 69 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the FIFO read-side engine
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - two-entry output buffer (head + skid) with occupancy FSM
module fifo_out_skid
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  m_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  pop,
   output logic [1:0]            occ_cnt
);

   occ_e                  state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OCC_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      pop     = (state_q != OCC_EMPTY) & m_ready;
      case (state_q)
         OCC_EMPTY: begin
            if (push) begin
               head_d  = push_data;
               state_d = OCC_ONE;
            end
         end
         OCC_ONE: begin
            // Head frees up on pop, so a same-cycle arrival replaces it directly.
            if (pop && push) begin
               head_d = push_data;
            end else if (pop) begin
               state_d = OCC_EMPTY;
            end else if (push) begin
               skid_d  = push_data;
               state_d = OCC_TWO;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               head_d  = skid_q;
               state_d = OCC_ONE;
            end
         end
         default: state_d = OCC_EMPTY;
      endcase
   end

   assign m_valid = (state_q != OCC_EMPTY);
   assign m_data  = head_q;
   assign occ_cnt = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a 1-cycle-latency FIFO read port onto a valid/ready stream
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_cs,
   output logic                  fifo_rd_ena,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic [CNT_WIDTH-1:0]  beat_cnt,
   output logic                  idle
);

   logic                 inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [1:0]           occ_cnt;
   logic                 pop;
   logic                 issue;
   logic [2:0]           credit_used;

   fifo_out_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (fifo_data),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .pop       (pop),
      .occ_cnt   (occ_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         inflight_q <= inflight_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // A new read needs a free slot after this cycle's pop, counting the word already in flight.
   always_comb begin
      credit_used = {1'b0, occ_cnt} + {2'b00, inflight_q} - {2'b00, pop};
      issue       = en & ~fifo_empty & (credit_used <= 3'd1);
      inflight_d  = issue;
      beat_cnt_d  = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
   end

   assign fifo_rd_ena = issue;
   assign fifo_cs     = issue;
   assign beat_cnt    = beat_cnt_q;
   assign idle        = ~inflight_q & (occ_cnt == 2'd0);

   credit_bound_a: assert property (@(posedge clk) disable iff (rst)
      ({1'b0, occ_cnt} + {2'b00, inflight_q}) <= 3'd2);

endmodule
